// File: rtl/text_console.sv
// text_console: character-cell console buffer with a cursor, hardware scrolling
// through a rotating top-row pointer, a registered display read port and a cursor
// blink generator. The whole buffer is cleared after reset, and one row is cleared
// after each scroll.
module text_console #(
    parameter int          COLS      = 70,
    parameter int          ROWS      = 30,
    parameter logic [7:0]  BLANK     = 8'h20,
    parameter int          BLINK_DIV = 25000000,
    localparam int         CW        = $clog2(COLS),
    localparam int         RW        = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          cur_vis
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int BW    = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SCROLL
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [RW-1:0]   top;
    logic [BW-1:0]   blink_cnt;
    logic [7:0]      mem [0:CELLS-1];

    logic [CW-1:0]   nxt_col;
    logic [RW-1:0]   nxt_row;
    logic [RW-1:0]   nxt_top;
    logic            to_scroll;
    logic            do_nl;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_char;
    logic            moved;
    logic [AW-1:0]   rd_addr;

    // Visible row to physical row: (r + t) mod ROWS, both operands already < ROWS.
    function automatic logic [RW-1:0] map_row(input logic [RW-1:0] r, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= (RW+1)'(ROWS))
            s = s - (RW+1)'(ROWS);
        return s[RW-1:0];
    endfunction

    // Linear cell address of a physical row and column.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    // Input acceptance depends only on the FSM state.
    assign in_ready = (state == IDLE);

    // Next cursor/top and the single write port request for this cycle.
    always_comb begin
        nxt_col   = cur_col;
        nxt_row   = cur_row;
        nxt_top   = top;
        to_scroll = 1'b0;
        do_nl     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_char   = BLANK;
        case (state)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
            end
            SCROLL: begin
                // top has already advanced, so the new bottom row is the one just above it
                wr_en   = 1'b1;
                wr_addr = cell_addr(map_row(RW'(ROWS-1), top), clr_cnt[CW-1:0]);
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(map_row(cur_row, top), cur_col);
                        wr_char = in_data;
                        if (cur_col == CW'(COLS-1))
                            do_nl = 1'b1;
                        else
                            nxt_col = cur_col + 1'b1;
                    end else if (in_data == 8'h0A || in_data == 8'h0D) begin
                        do_nl = 1'b1;
                    end else if (in_data == 8'h08) begin
                        if (cur_col != '0) begin
                            nxt_col = cur_col - 1'b1;
                            wr_en   = 1'b1;
                            wr_addr = cell_addr(map_row(cur_row, top), cur_col - 1'b1);
                        end else if (cur_row != '0) begin
                            nxt_col = CW'(COLS-1);
                            nxt_row = cur_row - 1'b1;
                            wr_en   = 1'b1;
                            wr_addr = cell_addr(map_row(cur_row - 1'b1, top), CW'(COLS-1));
                        end
                    end
                    if (do_nl) begin
                        nxt_col = '0;
                        if (cur_row < RW'(ROWS-1)) begin
                            nxt_row = cur_row + 1'b1;
                        end else begin
                            nxt_top   = (top == RW'(ROWS-1)) ? '0 : top + 1'b1;
                            to_scroll = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign moved = (nxt_col != cur_col) || (nxt_row != cur_row);

    // Control FSM: clear sequencing, cursor and top-row registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            cur_col <= '0;
            cur_row <= '0;
            top     <= '0;
        end else begin
            cur_col <= nxt_col;
            cur_row <= nxt_row;
            top     <= nxt_top;
            case (state)
                INIT: begin
                    if (clr_cnt == AW'(CELLS-1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (to_scroll) begin
                        state   <= SCROLL;
                        clr_cnt <= '0;
                    end
                end
                SCROLL: begin
                    if (clr_cnt == AW'(COLS-1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= INIT;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // Character storage write port.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_addr] <= wr_char;
    end

    assign rd_addr = cell_addr(map_row(rd_row, top), rd_col);

    // Registered display read; sees the cell contents before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= BLANK;
        else if (int'(rd_col) >= COLS || int'(rd_row) >= ROWS)
            rd_data <= BLANK;
        else
            rd_data <= mem[rd_addr];
    end

    // Cursor blink: toggle on each counter wrap, restart visible whenever the cursor moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            cur_vis   <= 1'b1;
        end else if (moved) begin
            blink_cnt <= '0;
            cur_vis   <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV-1)) begin
            blink_cnt <= '0;
            cur_vis   <= ~cur_vis;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: table-driven cursor vectors, hand-written
// multi-cycle sequences (init, scroll, reset during scroll, read-before-write, blink)
// and a random byte stream checked against a screen-array model.
module tb_text_console;

    localparam int         COLS  = 70;
    localparam int         ROWS  = 30;
    localparam int         DIV   = 8;
    localparam logic [7:0] BLANK = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [6:0] rd_col = '0;
    logic [4:0] rd_row = '0;
    logic [7:0] rd_data;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       cur_vis;

    always #5 clk = ~clk;

    text_console #(
        .COLS(COLS),
        .ROWS(ROWS),
        .BLANK(BLANK),
        .BLINK_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .rd_col(rd_col),
        .rd_row(rd_row),
        .rd_data(rd_data),
        .cur_col(cur_col),
        .cur_row(cur_row),
        .cur_vis(cur_vis)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int last_busy;

    // Model: screen in visible coordinates; scrolling shifts rows up.
    logic [7:0] scr [ROWS][COLS];
    int mcc, mcr;

    typedef struct {
        logic [7:0] data;
        int         col;
        int         row;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = BLANK;
        mcc = 0;
        mcr = 0;
    endtask

    task automatic model_newline(output bit sc);
        sc  = 1'b0;
        mcc = 0;
        if (mcr < ROWS-1) begin
            mcr++;
        end else begin
            for (int r = 0; r < ROWS-1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = BLANK;
            sc = 1'b1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit sc);
        sc = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mcr][mcc] = b;
            if (mcc == COLS-1) model_newline(sc);
            else mcc++;
        end else if (b == 8'h0A || b == 8'h0D) begin
            model_newline(sc);
        end else if (b == 8'h08) begin
            if (mcc > 0) begin
                mcc--;
                scr[mcr][mcc] = BLANK;
            end else if (mcr > 0) begin
                mcr--;
                mcc = COLS-1;
                scr[mcr][mcc] = BLANK;
            end
        end
    endtask

    // Precondition: called at a negedge. Counts negedges with in_ready low.
    task automatic count_busy(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_cell(input int c, input int r, output logic [7:0] v);
        @(negedge clk);
        rd_col = 7'(c);
        rd_row = 5'(r);
        @(posedge clk);
        #1 v = rd_data;
    endtask

    task automatic check_screen(input string name);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(c, r, v);
                if (v !== scr[r][c]) bad++;
            end
        check(name, bad, 0);
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        bit sc;
        int busy;
        g = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_byte(b, sc);
        @(negedge clk);
        count_busy(busy);
        last_busy = busy;
        check("busy", busy, sc ? COLS : 0);
        check("cur_col", cur_col, mcc);
        check("cur_row", cur_row, mcr);
    endtask

    task automatic do_reset(input int hold);
        int busy;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (hold) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_cur_col", cur_col, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_cur_vis", cur_vis, 1);
        check("rst_rd_data", rd_data, BLANK);
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        count_busy(busy);
        check("init_busy", busy, ROWS*COLS);
        check("init_col", cur_col, 0);
        check("init_row", cur_row, 0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] b;
        bit sc;
        int pick;

        tbl[0]  = '{8'h41, 1, 0};
        tbl[1]  = '{8'h07, 1, 0};
        tbl[2]  = '{8'h42, 2, 0};
        tbl[3]  = '{8'h08, 1, 0};
        tbl[4]  = '{8'h0D, 0, 1};
        tbl[5]  = '{8'h08, 69, 0};
        tbl[6]  = '{8'h08, 68, 0};
        tbl[7]  = '{8'h0A, 0, 1};
        tbl[8]  = '{8'h7E, 1, 1};
        tbl[9]  = '{8'h7F, 1, 1};
        tbl[10] = '{8'h1F, 1, 1};
        tbl[11] = '{8'h08, 0, 1};
        tbl[12] = '{8'h08, 69, 0};

        // Power-up with a byte offered during reset; it must not land.
        do_reset(3);
        check_screen("init_blank");

        // Table-driven cursor behaviour.
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].data);
            check("tbl_col", cur_col, tbl[i].col);
            check("tbl_row", cur_row, tbl[i].row);
        end

        // Blink restarts visible after the last move and toggles every DIV cycles.
        for (int k = 0; k < 20; k++) begin
            check("cur_vis", cur_vis, ((k / DIV) % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end

        read_cell(0, 0, v);    check("rd_0_0", v, 8'h41);
        read_cell(1, 0, v);    check("rd_1_0", v, BLANK);
        read_cell(0, 1, v);    check("rd_0_1", v, BLANK);
        read_cell(70, 0, v);   check("rd_col_oob", v, BLANK);
        read_cell(0, 30, v);   check("rd_row_oob", v, BLANK);
        read_cell(127, 31, v); check("rd_both_oob", v, BLANK);

        // Read-before-write on the cursor cell (69,0).
        @(negedge clk);
        rd_col   = 7'd69;
        rd_row   = 5'd0;
        in_valid = 1'b1;
        in_data  = 8'h51;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_byte(8'h51, sc);
        check("rbw_old", rd_data, BLANK);
        @(posedge clk);
        #1 check("rbw_new", rd_data, 8'h51);
        check("rbw_col", cur_col, 0);
        check("rbw_row", cur_row, 1);
        check_screen("table_screen");

        // Backspace at home, then a full row of printable bytes wraps without scrolling.
        do_reset(1);
        send(8'h08);
        check("bs_home_col", cur_col, 0);
        check("bs_home_row", cur_row, 0);
        for (int i = 0; i < COLS; i++)
            send(8'h61 + 8'(i % 26));
        check("row_wrap_busy", last_busy, 0);
        check("row_wrap_col", cur_col, 0);
        check("row_wrap_row", cur_row, 1);
        read_cell(69, 0, v); check("rd_69_0", v, 8'h61 + 8'(69 % 26));
        check_screen("row_screen");

        // Fill every row with its index character, then scroll with LF on the last row.
        do_reset(1);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS-1; c++)
                send(8'h30 + 8'(r));
            send(8'h0A);
        end
        check("scroll_busy", last_busy, COLS);
        check("scroll_col", cur_col, 0);
        check("scroll_row", cur_row, ROWS-1);
        read_cell(5, 0, v);  check("scroll_row0", v, 8'h31);
        read_cell(5, 28, v); check("scroll_row28", v, 8'h30 + 8'(ROWS-1));
        read_cell(5, 29, v); check("scroll_row29", v, BLANK);
        check_screen("scroll_screen");

        // Reset in the middle of a scroll restarts the full clear.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_scroll_busy", in_ready, 0);
        do_reset(1);
        check_screen("rst_scroll_screen");

        // Random byte stream against the model.
        for (int i = 0; i < 900; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 70)      b = 8'($urandom_range(32, 126));
            else if (pick < 78) b = 8'h0A;
            else if (pick < 83) b = 8'h0D;
            else if (pick < 93) b = 8'h08;
            else if (pick < 96) b = 8'($urandom_range(127, 255));
            else                b = 8'h1B;
            send(b);
            if (i % 60 == 0) begin
                read_cell($urandom_range(70, 127), $urandom_range(0, 31), v);
                check("rand_oob", v, BLANK);
                pick = $urandom_range(0, ROWS-1);
                read_cell(mcc, pick, v);
                check("rand_rd", v, scr[pick][mcc]);
            end
        end
        check_screen("rand_screen");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 The block SHALL take the following parameters:
  COLS  70  characters per row
  ROWS  30  rows per screen
  BLANK  8'h20  fill character
  BLINK_DIV  25000000  clk cycles per cursor-visibility toggle
REQ-002 Derived widths: CW = clog2(COLS), RW = clog2(ROWS); storage SHALL hold COLS*ROWS 8-bit cells.
REQ-003 The block SHALL have the following ports, clock and reset first:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  in_valid  in  1  ASCII byte offered
  in_data  in  8  ASCII byte
  in_ready  out  1  byte accepted when in_valid & in_ready at posedge
  rd_col  in  CW  display-read column
  rd_row  in  RW  display-read row (0 = top visible row)
  rd_data  out  8  character at (rd_col, rd_row)
  cur_col  out  CW  cursor column
  cur_row  out  RW  cursor row (visible coordinates)
  cur_vis  out  1  cursor blink phase

Function
REQ-004 The FSM SHALL have three states: INIT (clear all cells), IDLE (accept bytes), SCROLL (clear one row).
REQ-005 in_ready SHALL be 1 only in IDLE; it SHALL be combinational from state only, with no dependency on in_valid.
REQ-006 In INIT, the block SHALL write BLANK to one cell per cycle, addresses 0..COLS*ROWS-1, then enter IDLE on the following cycle (COLS*ROWS cycles with in_ready = 0).
REQ-007 A write to visible row r SHALL target physical row (r + top) mod ROWS; top SHALL be an RW-bit register.
REQ-008 An accepted printable byte (0x20-0x7E) SHALL be written at (cur_col, cur_row) in the same clock edge; cur_col SHALL then increment.
REQ-009 If the printable byte lands at cur_col = COLS-1, the block SHALL perform a newline instead of the increment.
REQ-010 An accepted LF (0x0A) or CR (0x0D) SHALL perform a newline.
REQ-011 Newline: cur_col <= 0; if cur_row < ROWS-1, cur_row SHALL increment and the block SHALL stay in IDLE.
REQ-012 Newline with cur_row = ROWS-1 SHALL scroll: top <= (top+1) mod ROWS, cur_row unchanged, enter SCROLL.
REQ-013 In SCROLL, the block SHALL write BLANK to the new bottom physical row, one cell per cycle, for COLS cycles, then return to IDLE.
REQ-014 An accepted BS (0x08) with cur_col > 0 SHALL set cur_col <= cur_col-1 and write BLANK at the new position.
REQ-015 BS with cur_col = 0 and cur_row > 0 SHALL move the cursor to (COLS-1, cur_row-1) and write BLANK there.
REQ-016 BS at (0,0) SHALL be consumed with no effect.
REQ-017 All other byte values SHALL be consumed and ignored, with no write and no cursor change.
REQ-018 rd_data SHALL be registered with 1-cycle latency from rd_col/rd_row, applying the top mapping of REQ-007.
REQ-019 rd_col >= COLS or rd_row >= ROWS SHALL return BLANK.
REQ-020 If a read and a write hit the same cell in the same cycle, rd_data SHALL return the old value (read-before-write).
REQ-021 A BLINK_DIV counter SHALL toggle cur_vis on each wrap; the counter SHALL restart at 0 with cur_vis = 1 whenever the cursor moves.

Reset
REQ-022 On rst, the block SHALL reset: state <= INIT, clear counter 0, cur_col 0, cur_row 0, top 0, cur_vis 1, blink counter 0, rd_data BLANK, in_ready 0.
REQ-023 rst SHALL dominate all other inputs.
REQ-024 rst during SCROLL or INIT SHALL restart INIT from address 0.
REQ-025 A byte presented during reset SHALL NOT be accepted.

Verification (COLS=70, ROWS=30)
REQ-026 Release rst -> in_ready = 0 for exactly 2100 cycles, then 1; every (col,row) read returns 8'h20.
REQ-027 Send 0x41 -> read (0,0) returns 0x41 one cycle after address; cursor (1,0); send 0x07 -> no change.
REQ-028 Send 70 printable bytes from (0,0) -> last at (69,0); cursor (0,1); no scroll.
REQ-029 Fill rows 0-29 with row-index characters, cursor at row 29, send 0x0A -> in_ready low 70 cycles; visible row 0 shows old row 1; row 29 reads all 0x20; cursor (0,29).
REQ-030 Cursor (0,1), send 0x08 -> cursor (69,0), cell (69,0) = 0x20; at (0,0), send 0x08 -> no change.
REQ-031 Assert rst for 1 cycle at SCROLL cycle 30 -> in_ready low for 2100 cycles; screen blank; cursor (0,0); top = 0.
